// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - funct3 access codes (F3_B, F3_H, F3_W, F3_BU, F3_HU)
//   - FSM state encoding (IDLE, BUSY, DONE)
//   - width of the BUSY timeout counter
//   - f3_legal(): checks whether a funct3 code is a supported access
//     for the requested direction
package lsu_pkg;

  localparam int TO_CNT_W = 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  // Loads accept the signed and unsigned byte/halfword forms plus word.
  // Stores have no unsigned forms.
  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
    logic ok;
    ok = 1'b0;
    if (is_store) begin
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    end else begin
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
    end
    return ok;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory bus between the load/store unit and data memory.
//   mem_req   LSU -> mem  request, held high until mem_ack
//   mem_we    LSU -> mem  1 = write, 0 = read
//   mem_addr  LSU -> mem  word-aligned address
//   mem_be    LSU -> mem  byte enables (4'b1111 on reads)
//   mem_wdata LSU -> mem  store data placed in the enabled lanes
//   mem_ack   mem -> LSU  access accepted / read data valid this cycle
//   mem_rdata mem -> LSU  read data
// Modports: master (LSU side), slave (memory side).
interface lsu_if;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering for the load/store unit.
//   funct3_i    access width/sign code
//   addr_lo_i   low two address bits (byte offset in the word)
//   wdata_i     raw store data
//   rdata_i     raw read word from memory
//   be_o        store byte enables
//   wdata_o     store data replicated into every lane
//   load_data_o extracted and extended load result
//   misalign_o  access is misaligned and must trap
// Configuration macro: MISALIGN_TRAP_EN. When undefined, misalign_o is
// tied low and the offending low address bits are simply ignored.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o,
  output logic        misalign_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Store side: replicating the datum means the enabled lane always
  // carries the right bytes without a barrel shifter.
  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
      end
    endcase
  end

  // Load side: halfwords only look at addr[1], words ignore both bits.
  always_comb begin
    byte_sel = rdata_i[7:0];
    case (addr_lo_i)
      2'd0: byte_sel = rdata_i[7:0];
      2'd1: byte_sel = rdata_i[15:8];
      2'd2: byte_sel = rdata_i[23:16];
      2'd3: byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    load_data_o = rdata_i;
    case (funct3_i)
      F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data_o = {24'h0, byte_sel};
      F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data_o = {16'h0, half_sel};
      default: load_data_o = rdata_i;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    misalign_o = 1'b0;
    if (funct3_i[1:0] == 2'b01) misalign_o = addr_lo_i[0];
    else if (funct3_i[1:0] == 2'b10) misalign_o = (addr_lo_i != 2'b00);
  end
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage of the single-cycle RV32I datapath. Uses the ALU
// result as effective address and rs2 as store data, runs a req/ack
// handshake to data memory, stalls the core while the access is in
// flight and returns extended load data for write-back.
//   clk, reset  clock, synchronous active-high reset
//   mem_read    current instruction is a load
//   mem_write   current instruction is a store
//   funct3      access width/sign code
//   addr        effective address
//   wdata       store data
//   stall       hold PC / regfile write enable
//   done        one-cycle completion pulse
//   load_data   extended load result, valid with done
//   err         valid with done: illegal request, timeout, misalignment
//   mem         lsu_if.master data-memory bus
// Parameter TIMEOUT_CYCLES (1..255): BUSY cycles without mem_ack before
// the access is aborted with err.
// Configuration macro: MISALIGN_TRAP_EN (see lsu_align).
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        err,
  lsu_if.master       mem
);

  localparam logic [TO_CNT_W-1:0] TO_LIMIT = TO_CNT_W'(TIMEOUT_CYCLES);
  localparam logic [TO_CNT_W-1:0] TO_MAX   = '1;

  lsu_state_e          state_q;
  logic [2:0]          f3_q;
  logic [1:0]          addr_lo_q;
  logic [TO_CNT_W-1:0] cnt_q, cnt_d;
  logic                done_q, err_q;
  logic [31:0]         load_data_q;
  logic                mem_req_q, mem_we_q;
  logic [31:0]         mem_addr_q, mem_wdata_q;
  logic [3:0]          mem_be_q;

  logic                req;
  logic                illegal;
  logic [2:0]          aln_f3;
  logic [1:0]          aln_addr_lo;
  logic [3:0]          aln_be;
  logic [31:0]         aln_wdata, aln_load;
  logic                aln_misalign;

  assign req     = mem_read | mem_write;
  assign illegal = (mem_read & mem_write) | ~f3_legal(funct3, mem_write);

  // In IDLE the aligner decodes the incoming request; once BUSY it works
  // on the captured access so the read word is extracted correctly.
  assign aln_f3      = (state_q == IDLE) ? funct3    : f3_q;
  assign aln_addr_lo = (state_q == IDLE) ? addr[1:0] : addr_lo_q;

  lsu_align u_align (
    .funct3_i    (aln_f3),
    .addr_lo_i   (aln_addr_lo),
    .wdata_i     (wdata),
    .rdata_i     (mem.mem_rdata),
    .be_o        (aln_be),
    .wdata_o     (aln_wdata),
    .load_data_o (aln_load),
    .misalign_o  (aln_misalign)
  );

  assign cnt_d = (cnt_q == TO_MAX) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      f3_q        <= 3'b000;
      addr_lo_q   <= 2'b00;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      load_data_q <= 32'h0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_be_q    <= 4'h0;
      mem_wdata_q <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          if (req) begin
            if (illegal || aln_misalign) begin
              // Rejected before touching the bus.
              state_q     <= DONE;
              done_q      <= 1'b1;
              err_q       <= 1'b1;
              load_data_q <= 32'h0;
            end else begin
              state_q     <= BUSY;
              f3_q        <= funct3;
              addr_lo_q   <= addr[1:0];
              cnt_q       <= '0;
              mem_req_q   <= 1'b1;
              mem_we_q    <= mem_write;
              mem_addr_q  <= {addr[31:2], 2'b00};
              mem_be_q    <= mem_write ? aln_be : 4'b1111;
              mem_wdata_q <= aln_wdata;
            end
          end
        end
        BUSY: begin
          // An ack in the last allowed cycle still completes normally.
          if (mem.mem_ack) begin
            state_q     <= DONE;
            mem_req_q   <= 1'b0;
            done_q      <= 1'b1;
            err_q       <= 1'b0;
            load_data_q <= mem_we_q ? 32'h0 : aln_load;
          end else if (cnt_d == TO_LIMIT) begin
            state_q     <= DONE;
            mem_req_q   <= 1'b0;
            done_q      <= 1'b1;
            err_q       <= 1'b1;
            load_data_q <= 32'h0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          done_q    <= 1'b0;
          err_q     <= 1'b0;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  // Stall covers the request cycle itself so the PC holds before BUSY.
  assign stall = (state_q == BUSY) | ((state_q == IDLE) & req);

  assign done          = done_q;
  assign err           = err_q;
  assign load_data     = load_data_q;
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_be    = mem_be_q;
  assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, done, err;
  logic [31:0] load_data;

  int n_chk  = 0;
  int n_fail = 0;

  lsu_if bus ();

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .stall     (stall),
    .done      (done),
    .load_data (load_data),
    .err       (err),
    .mem       (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; outputs are sampled 2ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    mem_read  = rd;
    mem_write = wr;
    funct3    = f3;
    addr      = a;
    wdata     = d;
    #1;
  endtask

  task automatic idle_inputs();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    funct3    = 3'b000;
    addr      = 32'h0;
    wdata     = 32'h0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst_done",  {31'h0, done},        32'h0);
    chk("rst_err",   {31'h0, err},         32'h0);
    chk("rst_stall", {31'h0, stall},       32'h0);
    chk("rst_req",   {31'h0, bus.mem_req}, 32'h0);
    chk("rst_we",    {31'h0, bus.mem_we},  32'h0);
    chk("rst_addr",  bus.mem_addr,         32'h0);
    chk("rst_be",    {28'h0, bus.mem_be},  32'h0);
    chk("rst_wdata", bus.mem_wdata,        32'h0);
    chk("rst_ld",    load_data,            32'h0);
    reset = 1'b0;
    tick();

    // LW 0x100, ack three cycles after mem_req rises
    drive(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    chk("lw_stall_c0", {31'h0, stall}, 32'h1);
    tick();
    chk("lw_req_c1",   {31'h0, bus.mem_req}, 32'h1);
    chk("lw_we_c1",    {31'h0, bus.mem_we},  32'h0);
    chk("lw_addr_c1",  bus.mem_addr,         32'h100);
    chk("lw_be_c1",    {28'h0, bus.mem_be},  32'hF);
    chk("lw_stall_c1", {31'h0, stall},       32'h1);
    tick();
    chk("lw_done_c2",  {31'h0, done},        32'h0);
    tick();
    chk("lw_stall_c3", {31'h0, stall},       32'h1);
    tick();
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'hDEADBEEF;
    tick();
    bus.mem_ack = 1'b0;
    chk("lw_done_c5",  {31'h0, done},        32'h1);
    chk("lw_ld_c5",    load_data,            32'hDEADBEEF);
    chk("lw_err_c5",   {31'h0, err},         32'h0);
    chk("lw_stall_c5", {31'h0, stall},       32'h0);
    chk("lw_req_c5",   {31'h0, bus.mem_req}, 32'h0);
    idle_inputs();
    tick();
    chk("lw_done_c6",  {31'h0, done},        32'h0);

    // LB 0x103 with same-cycle ack
    drive(1'b1, 1'b0, 3'b000, 32'h103, 32'h0);
    tick();
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'h80112233;
    tick();
    bus.mem_ack = 1'b0;
    chk("lb_done", {31'h0, done}, 32'h1);
    chk("lb_ld",   load_data,     32'hFFFFFF80);
    idle_inputs();
    tick();

    // LBU, same access
    drive(1'b1, 1'b0, 3'b100, 32'h103, 32'h0);
    tick();
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'h80112233;
    tick();
    bus.mem_ack = 1'b0;
    chk("lbu_done", {31'h0, done}, 32'h1);
    chk("lbu_ld",   load_data,     32'h00000080);
    idle_inputs();
    tick();

    // LH 0x102: upper halfword, sign-extended
    drive(1'b1, 1'b0, 3'b001, 32'h102, 32'h0);
    tick();
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'h9ABC1234;
    tick();
    bus.mem_ack = 1'b0;
    chk("lh_ld", load_data, 32'hFFFF9ABC);
    idle_inputs();
    tick();

    // SH 0x202
    drive(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000ABCD);
    tick();
    chk("sh_we",    {31'h0, bus.mem_we},  32'h1);
    chk("sh_addr",  bus.mem_addr,         32'h200);
    chk("sh_be",    {28'h0, bus.mem_be},  32'hC);
    chk("sh_wdata", bus.mem_wdata,        32'hABCDABCD);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    chk("sh_done",  {31'h0, done}, 32'h1);
    chk("sh_err",   {31'h0, err},  32'h0);
    idle_inputs();
    tick();

    // SB 0x101
    drive(1'b0, 1'b1, 3'b000, 32'h101, 32'h12345677);
    tick();
    chk("sb_be",    {28'h0, bus.mem_be}, 32'h2);
    chk("sb_wdata", bus.mem_wdata,       32'h77777777);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    chk("sb_done",  {31'h0, done}, 32'h1);
    idle_inputs();
    tick();

    // Timeout with TIMEOUT_CYCLES = 4
    drive(1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
    tick();
    tick();
    tick();
    tick();
    chk("to_req_c4",  {31'h0, bus.mem_req}, 32'h1);
    chk("to_done_c4", {31'h0, done},        32'h0);
    tick();
    chk("to_req_c5",  {31'h0, bus.mem_req}, 32'h0);
    chk("to_done_c5", {31'h0, done},        32'h1);
    chk("to_err_c5",  {31'h0, err},         32'h1);
    chk("to_ld_c5",   load_data,            32'h0);
    idle_inputs();
    tick();

    // Next request after timeout is accepted
    drive(1'b1, 1'b0, 3'b010, 32'h304, 32'h0);
    tick();
    chk("after_to_req", {31'h0, bus.mem_req}, 32'h1);
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'h13579BDF;
    tick();
    bus.mem_ack = 1'b0;
    chk("after_to_err", {31'h0, err}, 32'h0);
    chk("after_to_ld",  load_data,    32'h13579BDF);
    idle_inputs();
    tick();

    // Illegal: load and store together
    drive(1'b1, 1'b1, 3'b010, 32'h400, 32'h0);
    tick();
    chk("ill_both_done", {31'h0, done},        32'h1);
    chk("ill_both_err",  {31'h0, err},         32'h1);
    chk("ill_both_req",  {31'h0, bus.mem_req}, 32'h0);
    idle_inputs();
    tick();

    // Illegal: store with unsigned funct3
    drive(1'b0, 1'b1, 3'b100, 32'h400, 32'h0);
    tick();
    chk("ill_f3_err", {31'h0, err},         32'h1);
    chk("ill_f3_req", {31'h0, bus.mem_req}, 32'h0);
    idle_inputs();
    tick();

    // Misaligned LW 0x102
    drive(1'b1, 1'b0, 3'b010, 32'h102, 32'h0);
    tick();
`ifdef MISALIGN_TRAP_EN
    chk("mis_req",  {31'h0, bus.mem_req}, 32'h0);
    chk("mis_done", {31'h0, done},        32'h1);
    chk("mis_err",  {31'h0, err},         32'h1);
    idle_inputs();
    tick();
`else
    chk("mis_req",  {31'h0, bus.mem_req}, 32'h1);
    chk("mis_addr", bus.mem_addr,         32'h100);
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'hCAFEF00D;
    tick();
    bus.mem_ack = 1'b0;
    chk("mis_err",  {31'h0, err}, 32'h0);
    chk("mis_ld",   load_data,    32'hCAFEF00D);
    idle_inputs();
    tick();
`endif

    // Reset while BUSY
    drive(1'b1, 1'b0, 3'b010, 32'h500, 32'h0);
    tick();
    chk("mid_req_c1", {31'h0, bus.mem_req}, 32'h1);
    reset = 1'b1;
    idle_inputs();
    tick();
    reset = 1'b0;
    chk("mid_req_c2",   {31'h0, bus.mem_req}, 32'h0);
    chk("mid_addr_c2",  bus.mem_addr,         32'h0);
    chk("mid_be_c2",    {28'h0, bus.mem_be},  32'h0);
    chk("mid_stall_c2", {31'h0, stall},       32'h0);
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'h11111111;
    tick();
    chk("mid_done_c3",  {31'h0, done}, 32'h0);
    tick();
    bus.mem_ack = 1'b0;
    chk("mid_done_c4",  {31'h0, done}, 32'h0);
    chk("mid_ld_c4",    load_data,     32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
